// File: rtl/exchange_test_if.sv
// Shared types and the handshake/bus interface of the replica-exchange test.
//
// exchange_test_pkg
//   command_t : ordering option command (OR0 pairs even ids, OR1 pairs odd ids)
//   opt_t     : ordering option struct; only .command is meaningful here
//
// exchange_test_if signals
//   start        : one-cycle launch pulse (requester -> tester)
//   opt          : ordering option, sampled on start
//   self_energy  : 24-bit unsigned energy of this replica, sampled on start
//   folw_energy  : 24-bit unsigned energy of replica id+1, sampled on start
//   beta_diff    : 16-bit unsigned beta(id+1) - beta(id), sampled on start
//   log_rand     : 41-bit signed ln(r) <= 0, sampled when the multiply ends
//   busy         : high from the cycle after an accepted start through done
//   done         : one-cycle pulse when delta/out_exchange are updated
//   delta        : 41-bit signed delta of the last test, held
//   out_exchange : exchange accepted for pair (id, id+1), held
//   state_dbg    : current controller state (IDLE=0, MUL=1, CMP=2, DONE=3)
//
// Handshake: start is only honoured while the tester is idle (busy low and
// done low); a start seen at any other time is dropped, never queued. Every
// accepted start produces exactly one done pulse unless reset intervenes.

package exchange_test_pkg;
    typedef enum logic {
        OR0 = 1'b0,
        OR1 = 1'b1
    } command_t;

    typedef struct packed {
        command_t command;
    } opt_t;
endpackage

interface exchange_test_if;
    import exchange_test_pkg::*;

    logic               start;
    opt_t               opt;
    logic [23:0]        self_energy;
    logic [23:0]        folw_energy;
    logic [15:0]        beta_diff;
    logic signed [40:0] log_rand;
    logic               busy;
    logic               done;
    logic signed [40:0] delta;
    logic               out_exchange;
    logic [1:0]         state_dbg;

    modport master (
        output start, opt, self_energy, folw_energy, beta_diff, log_rand,
        input  busy, done, delta, out_exchange, state_dbg
    );

    modport slave (
        input  start, opt, self_energy, folw_energy, beta_diff, log_rand,
        output busy, done, delta, out_exchange, state_dbg
    );
endinterface

// File: rtl/exchange_test.sv
// Replica-exchange Metropolis test between replica id and replica id+1.
//
// delta = beta_diff * (self_energy - folw_energy) is formed by a 16-step
// shift-add multiply, then the exchange is accepted iff delta + ln(r) < 0.
// The held result feeds the neighbouring exchange-command stages.
//
// Ports
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : exchange_test_if.slave (start/operands in, busy/done/result out)
//
// Parameters
//   id          : replica index of this instance
//   replica_num : total number of replicas (the last replica has no follower)

module exchange_test
    import exchange_test_pkg::*;
#(
    parameter int id          = 0,
    parameter int replica_num = 32
) (
    input  logic          clk,
    input  logic          reset,
    exchange_test_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic IS_LAST = (id == replica_num - 1);
    localparam logic IS_EVEN = ((id % 2) == 0);

    state_t             state;
    logic signed [40:0] diff_x;     // sign-extended energy difference
    logic signed [40:0] acc;        // product accumulator
    logic signed [40:0] lr_q;       // ln(r) captured as the multiply ends
    logic [15:0]        mult;       // remaining multiplier bits
    logic [3:0]         cnt;        // current bit position
    logic               active;     // this pair is tested under current opt
    logic               busy_q;
    logic               done_q;
    logic               xchg_q;
    logic signed [40:0] delta_q;

    logic               parity_match;
    logic signed [24:0] diff_in;
    logic signed [40:0] addend;
    logic signed [41:0] sum;

    assign parity_match = IS_EVEN ? (bus.opt.command == OR0)
                                  : (bus.opt.command == OR1);

    // Zero-extend both unsigned energies so the 25-bit difference is exact.
    assign diff_in = $signed({1'b0, bus.self_energy}) - $signed({1'b0, bus.folw_energy});
    assign addend  = diff_x <<< cnt;

    // One extra bit so acc + ln(r) can never wrap.
    assign sum = {acc[40], acc} + {lr_q[40], lr_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            diff_x  <= '0;
            acc     <= '0;
            lr_q    <= '0;
            mult    <= '0;
            cnt     <= '0;
            active  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            xchg_q  <= 1'b0;
            delta_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        diff_x <= {{16{diff_in[24]}}, diff_in};
                        mult   <= bus.beta_diff;
                        acc    <= '0;
                        cnt    <= '0;
                        active <= parity_match && !IS_LAST;
                        busy_q <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (mult[0]) begin
                        acc <= acc + addend;
                    end
                    mult <= mult >> 1;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        lr_q  <= bus.log_rand;
                        state <= CMP;
                    end
                end
                CMP: begin
                    // Results are registered here so they appear with done in DONE.
                    // Inactive pairs still run the full sequence for uniform timing.
                    done_q  <= 1'b1;
                    xchg_q  <= active && sum[41];
                    delta_q <= active ? acc : '0;
                    state   <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.delta        = delta_q;
    assign bus.out_exchange = xchg_q;
    assign bus.state_dbg    = state;

endmodule
